// File: rtl/sdac_model_if.sv
// Request/response bundle of the sequential DAC model: code strobe in,
// held real analog value plus status pulses out.
interface sdac_model_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dig_in;
  real              ana_out;
  logic             busy;
  logic             eoc;
  logic             overrun;

  modport master (
    output start,
    output dig_in,
    input  ana_out,
    input  busy,
    input  eoc,
    input  overrun
  );

  modport slave (
    input  start,
    input  dig_in,
    output ana_out,
    output busy,
    output eoc,
    output overrun
  );
endinterface

// File: rtl/sdac_model.sv
// Behavioural charge-redistribution DAC: resolves a code MSB-first, one bit
// per clock, into a real accumulator and publishes it with an eoc pulse.
module sdac_model #(
  parameter int  WIDTH = 8,
  parameter real VREF  = 1.0
) (
  input  logic         clk,
  input  logic         rst,
  sdac_model_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] code_q;
  logic [WIDTH-1:0] pend_code_q;
  logic             pend_vld_q;
  logic [CW-1:0]    cnt_q;
  real              acc_q;
  real              acc_d;
  real              ana_q;
  logic             busy_q;
  logic             eoc_q;
  logic             ovr_q;

  // Weight of bit position cnt: VREF / 2**(WIDTH-cnt), an exact binary fraction.
  function automatic real bit_weight(input logic [CW-1:0] cnt);
    return VREF / real'(64'd1 << (WIDTH - int'(cnt)));
  endfunction

  // Unknown code bits resolve to 0 so the model never propagates X into reals.
  function automatic logic [WIDTH-1:0] clean_code(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = (d[i] === 1'b1);
    end
    return r;
  endfunction

  always_comb begin
    acc_d = acc_q;
    if (code_q[cnt_q]) begin
      acc_d = acc_q + bit_weight(cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ana_q      <= 0.0;
      acc_q      <= 0.0;
      cnt_q      <= CNT_TOP;
      pend_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      eoc_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (bus.start && $isunknown(bus.dig_in)) begin
        $warning("sdac_model: X/Z on dig_in at capture, treated as 0");
      end
      eoc_q <= 1'b0;
      ovr_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            code_q  <= clean_code(bus.dig_in);
            acc_q   <= 0.0;
            cnt_q   <= CNT_TOP;
            state_q <= S_CONV;
            busy_q  <= 1'b1;
          end
        end
        S_CONV: begin
          acc_q <= acc_d;
          if (cnt_q == '0) begin
            ana_q   <= acc_d;
            eoc_q   <= 1'b1;
            state_q <= S_DONE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
          // A second request while one is already pending replaces it.
          if (bus.start) begin
            pend_code_q <= clean_code(bus.dig_in);
            pend_vld_q  <= 1'b1;
            ovr_q       <= pend_vld_q;
          end
        end
        S_DONE: begin
          acc_q <= 0.0;
          cnt_q <= CNT_TOP;
          if (pend_vld_q) begin
            code_q     <= pend_code_q;
            pend_vld_q <= bus.start;
            if (bus.start) begin
              pend_code_q <= clean_code(bus.dig_in);
            end
            state_q <= S_CONV;
            busy_q  <= 1'b1;
          end else if (bus.start) begin
            code_q  <= clean_code(bus.dig_in);
            state_q <= S_CONV;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ana_out = ana_q;
  assign bus.busy    = busy_q;
  assign bus.eoc     = eoc_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_sdac_model.sv
// Scoreboard bench for sdac_model: expected conversions are queued at issue,
// a negedge monitor pops and compares them whenever eoc is seen.
module tb_sdac_model;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;
  int   ovr_cnt;

  real  exp_val_q[$];
  int   exp_cyc_q[$];
  int   exp_code_q[$];

  sdac_model_if #(.WIDTH(W)) bus ();

  sdac_model #(.WIDTH(W), .VREF(1.0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", name, got, want, cyc);
    end
  endtask

  task automatic chk_real(input string name, input real got, input real want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %f want %f (cyc %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every eoc must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.overrun) ovr_cnt++;
    if (bus.eoc) begin
      if (exp_val_q.size() == 0) begin
        chk_int("unexpected_eoc", 1, 0);
      end else begin
        real ev;
        int  ec;
        int  ecode;
        int  q;
        ev    = exp_val_q.pop_front();
        ec    = exp_cyc_q.pop_front();
        ecode = exp_code_q.pop_front();
        chk_real("eoc_ana_out", bus.ana_out, ev);
        chk_int("eoc_cycle", cyc, ec);
        q = $rtoi(bus.ana_out * 256.0);
        checks++;
        if (q < ecode - 2 || q > ecode + 2) begin
          errors++;
          $display("FAIL adc_reconstruct: got %0d want %0d +-2", q, ecode);
        end
      end
    end
  end

  // Drive one start strobe from a negedge; ecyc==0 means the default latency.
  task automatic issue(input logic [7:0] code, input bit push, input real expv,
                       input int ecyc);
    if (push) begin
      exp_val_q.push_back(expv);
      exp_cyc_q.push_back((ecyc == 0) ? cyc + 1 + W : ecyc);
      exp_code_q.push_back(int'(code));
    end
    bus.start  = 1'b1;
    bus.dig_in = code;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  initial begin
    int n;
    int ovr0;
    logic [7:0] rc;
    errors     = 0;
    checks     = 0;
    ovr_cnt    = 0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.dig_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_real("reset_ana", bus.ana_out, 0.0);
    chk_int("reset_busy", int'(bus.busy), 0);
    chk_int("reset_eoc", int'(bus.eoc), 0);
    chk_int("reset_ovr", int'(bus.overrun), 0);

    // 0x80: busy for 8 cycles, ana_out held at 0.0 until eoc
    issue(8'h80, 1'b1, 0.5, 0);
    for (int i = 0; i < 8; i++) begin
      chk_int("t1_busy", int'(bus.busy), 1);
      chk_real("t1_ana_hold", bus.ana_out, 0.0);
      @(negedge clk);
    end
    chk_int("t1_busy_end", int'(bus.busy), 0);
    chk_int("t1_eoc", int'(bus.eoc), 1);
    @(negedge clk);
    chk_int("t1_eoc_one_cycle", int'(bus.eoc), 0);
    repeat (3) @(negedge clk);

    // 0xFF then 0x00 issued during DONE; old value held through CONV
    issue(8'hFF, 1'b1, 0.99609375, 0);
    repeat (8) @(negedge clk);
    issue(8'h00, 1'b1, 0.0, 0);
    for (int i = 0; i < 8; i++) begin
      chk_real("t2_ana_hold", bus.ana_out, 0.99609375);
      @(negedge clk);
    end
    repeat (4) @(negedge clk);

    // 0x40 then 0xC0 queued as pending: eoc 9 cycles apart, no overrun
    ovr0 = ovr_cnt;
    n = cyc;
    issue(8'h40, 1'b1, 0.25, 0);
    @(negedge clk);
    issue(8'hC0, 1'b1, 0.75, n + 18);
    repeat (20) @(negedge clk);
    chk_int("t3_no_overrun", ovr_cnt - ovr0, 0);

    // 0x10, then 0x20 overwritten by 0x30: one overrun, 0x20 never output
    ovr0 = ovr_cnt;
    n = cyc;
    issue(8'h10, 1'b1, 0.0625, 0);
    issue(8'h20, 1'b0, 0.0, 0);
    chk_int("t4_ovr_quiet", int'(bus.overrun), 0);
    issue(8'h30, 1'b1, 0.1875, n + 18);
    chk_int("t4_ovr_pulse", int'(bus.overrun), 1);
    @(negedge clk);
    chk_int("t4_ovr_drop", int'(bus.overrun), 0);
    repeat (20) @(negedge clk);
    chk_int("t4_ovr_count", ovr_cnt - ovr0, 1);

    // Reset mid-conversion of 0xAA aborts it silently
    issue(8'hAA, 1'b0, 0.0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_int("t5_busy", int'(bus.busy), 0);
    chk_int("t5_eoc", int'(bus.eoc), 0);
    chk_real("t5_ana", bus.ana_out, 0.0);
    repeat (12) @(negedge clk);
    chk_real("t5_ana_still", bus.ana_out, 0.0);
    issue(8'h55, 1'b1, 0.33203125, 0);
    repeat (10) @(negedge clk);

    // Closed-loop reconstruction with random codes
    ovr0 = ovr_cnt;
    for (int k = 0; k < 5; k++) begin
      rc = 8'($urandom_range(0, 255));
      issue(rc, 1'b1, real'(rc) / 256.0, 0);
      repeat (10) @(negedge clk);
    end
    chk_int("t6_no_overrun", ovr_cnt - ovr0, 0);

    for (int t = 0; t < 50 && exp_val_q.size() != 0; t++) @(negedge clk);
    chk_int("scoreboard_drained", exp_val_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
